// File: rtl/pkt_rx_pkg.sv
// Shared types and sizing for the RX packet path: FSM states, descriptor layout,
// ring and beat geometry.
package pkt_rx_pkg;

    localparam int RX_DATA_WIDTH = 512;
    localparam int RX_KEEP_WIDTH = RX_DATA_WIDTH / 8;   // bytes per beat
    localparam int RX_ADDR_WIDTH = 8;
    localparam int RX_LEN_WIDTH  = 16;
    localparam int RX_RING_BEATS = 2 ** RX_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DROP
    } rx_state_t;

    typedef struct packed {
        logic [RX_ADDR_WIDTH-1:0] addr;
        logic [RX_LEN_WIDTH-1:0]  pkt_len;
        logic [RX_LEN_WIDTH-1:0]  byte_len;
    } rx_desc_t;

endpackage

// File: rtl/desc_fifo.sv
// First-word-fall-through descriptor queue between the RX writer and the
// rule-match engine; head is valid whenever empty is low.
module desc_fifo
    import pkt_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     push,
    input  rx_desc_t                 push_data,
    input  logic                     pop,
    output rx_desc_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    rx_desc_t        mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/packet_receiver.sv
// RX frame writer: stores CMAC beats into the packet ring, emits one descriptor per
// stored frame and drops frames that do not fit. Never backpressures the MAC.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a frame
// S_RECV | frame in progress, beats are being stored
// S_DROP | discarding the remainder of a frame
module packet_receiver
    import pkt_rx_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = RX_DATA_WIDTH,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = RX_ADDR_WIDTH,
    parameter int LEN_WIDTH       = RX_LEN_WIDTH,
    parameter int DESC_DEPTH      = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       mem_wr_en,
    output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [AXIS_DATA_WIDTH-1:0] mem_wr_data,
    output logic                       m_desc_valid,
    input  logic                       m_desc_ready,
    output logic [ADDR_WIDTH-1:0]      m_desc_addr,
    output logic [LEN_WIDTH-1:0]       m_desc_pkt_len,
    output logic [LEN_WIDTH-1:0]       m_desc_byte_len,
    input  logic                       s_rel_valid,
    input  logic [ADDR_WIDTH:0]        s_rel_beats,
    output logic [15:0]                drop_cnt_o
);

    localparam int RING_BEATS = 2 ** ADDR_WIDTH;
    localparam int FW         = ADDR_WIDTH + 1;
    localparam int LW         = $clog2(DESC_DEPTH) + 1;

    rx_state_t             state, state_nxt;
    logic [FW-1:0]         free_cnt, free_nxt;
    logic [FW:0]           free_sum;
    logic [ADDR_WIDTH-1:0] wr_ptr, pkt_start, frame_start;
    logic [LEN_WIDTH-1:0]  pkt_beats, cur_beats, beats_new, byte_len_new;
    logic                  push_req;
    rx_desc_t              push_desc, head;
    logic                  fifo_full, fifo_empty, desc_room;
    logic [LW-1:0]         fifo_level;
    logic                  beat, fits, store, commit, rewind, drop_inc;

    assign beat         = s_axis_tvalid & s_axis_tready;
    assign cur_beats    = (state == S_RECV) ? pkt_beats : '0;
    assign fits         = 32'(cur_beats) < 32'(free_cnt);
    assign beats_new    = cur_beats + LEN_WIDTH'(1);
    assign frame_start  = (state == S_RECV) ? pkt_start : wr_ptr;
    assign byte_len_new = (beats_new - LEN_WIDTH'(1)) * LEN_WIDTH'(AXIS_KEEP_WIDTH)
                        + LEN_WIDTH'($countones(s_axis_tkeep));
    // A descriptor registered last cycle but not yet in the FIFO still occupies a slot.
    assign desc_room    = !fifo_full && !(push_req && fifo_level == LW'(DESC_DEPTH - 1));

    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        commit    = 1'b0;
        rewind    = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            S_IDLE, S_RECV: begin
                if (beat) begin
                    if (fits) begin
                        store = 1'b1;
                        if (s_axis_tlast) begin
                            state_nxt = S_IDLE;
                            if (desc_room) begin
                                commit = 1'b1;
                            end else begin
                                rewind   = 1'b1;
                                drop_inc = 1'b1;
                            end
                        end else begin
                            state_nxt = S_RECV;
                        end
                    end else begin
                        rewind = 1'b1;
                        if (s_axis_tlast) begin
                            drop_inc  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DROP;
                        end
                    end
                end
            end
            S_DROP: begin
                if (beat && s_axis_tlast) begin
                    drop_inc  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Commit and release can land together; release past the ring size saturates.
    always_comb begin
        free_sum = {1'b0, free_cnt};
        if (commit) free_sum = free_sum - (FW+1)'(beats_new);
        if (s_rel_valid) free_sum = free_sum + {1'b0, s_rel_beats};
        if (free_sum > (FW+1)'(RING_BEATS)) free_nxt = FW'(RING_BEATS);
        else free_nxt = free_sum[FW-1:0];
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= S_IDLE;
            s_axis_tready <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            wr_ptr        <= '0;
            pkt_start     <= '0;
            pkt_beats     <= '0;
            free_cnt      <= FW'(RING_BEATS);
            push_req      <= 1'b0;
            push_desc     <= '0;
            drop_cnt_o    <= '0;
        end else begin
            state         <= state_nxt;
            s_axis_tready <= 1'b1;
            mem_wr_en     <= store;
            if (store) begin
                mem_wr_addr <= wr_ptr;
                mem_wr_data <= s_axis_tdata;
                pkt_start   <= frame_start;
                pkt_beats   <= beats_new;
            end
            if (rewind) wr_ptr <= frame_start;
            else if (store) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            push_req <= commit;
            if (commit) push_desc <= '{addr: frame_start, pkt_len: beats_new, byte_len: byte_len_new};
            free_cnt <= free_nxt;
            if (drop_inc) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .push      (push_req),
        .push_data (push_desc),
        .pop       (m_desc_valid & m_desc_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign m_desc_valid    = ~fifo_empty;
    assign m_desc_addr     = head.addr;
    assign m_desc_pkt_len  = head.pkt_len;
    assign m_desc_byte_len = head.byte_len;

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Receive-side counterpart of the packet transmitter. Accepts Ethernet frames from the CMAC RX AXI-Stream and writes 512-bit beats into a ring-organised packet memory.
- Emits one descriptor per stored frame (start address, beat count, byte count) to the rule-match engine over a valid/ready handshake.
- The downstream consumer returns ring space through a release port. Frames that do not fit are dropped; the block never backpressures the MAC.

Parameters:
AXIS_DATA_WIDTH, 512, stream/memory data width in bits (byte count = /8)
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
ADDR_WIDTH, 8, packet-memory address width; ring holds 2^ADDR_WIDTH beats
LEN_WIDTH, 16, width of beat/byte length fields
DESC_DEPTH, 4, descriptor FIFO depth (power of 2)

Ports:
clock_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
s_axis_tdata  in  AXIS_DATA_WIDTH  RX beat data
s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables, contiguous from bit 0
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  accept
mem_wr_en  out  1  packet-memory write strobe
mem_wr_addr  out  ADDR_WIDTH  write address
mem_wr_data  out  AXIS_DATA_WIDTH  write data
m_desc_valid  out  1  descriptor available
m_desc_ready  in  1  consumer takes descriptor
m_desc_addr  out  ADDR_WIDTH  first beat address
m_desc_pkt_len  out  LEN_WIDTH  frame length in beats (>=1)
m_desc_byte_len  out  LEN_WIDTH  frame length in bytes
s_rel_valid  in  1  release strobe (always accepted)
s_rel_beats  in  ADDR_WIDTH+1  beats returned to the ring
drop_cnt_o  out  16  dropped-frame counter, wraps

Behaviour:
- Reset: reset_ni is asynchronous, active-low; clock is clock_i. All outputs are 0. free_cnt = 2^ADDR_WIDTH, wr_ptr = pkt_start = 0, descriptor FIFO empty, state S_IDLE.
- tready: a register that is 0 in reset and 1 from the first clock_i edge after deassertion, then constant. A beat is accepted when tvalid & tready.
- States:
  - S_IDLE: waiting for the first beat.
  - S_RECV: frame in progress; beats are being stored.
  - S_DROP: discarding the remainder of the frame.
- Space rule: a beat is stored iff pkt_beats < free_cnt, where pkt_beats is the number of beats already stored for the current frame.
- S_IDLE, beat accepted:
  - If it fits: pkt_start = wr_ptr, write beat, pkt_beats = 1. If tlast, commit; else go to S_RECV.
  - If it does not fit: go to S_DROP, or stay in S_IDLE with drop_cnt++ if tlast.
- S_RECV, beat accepted:
  - If it fits: write, pkt_beats++. If tlast, commit and go to S_IDLE.
  - If it does not fit: wr_ptr <= pkt_start and go to S_DROP. If this beat has tlast, drop_cnt++ and go to S_IDLE instead.
- S_DROP: no writes. On tlast, drop_cnt++ and go to S_IDLE.
- Commit (tlast beat stored):
  - If descriptor FIFO not full: push {pkt_start, pkt_beats, byte_len}; free_cnt -= pkt_beats.
  - If descriptor FIFO full: discard the frame (wr_ptr <= pkt_start, drop_cnt++).
- Byte length: byte_len = (pkt_beats-1)*AXIS_KEEP_WIDTH + popcount(tkeep of last beat). Non-last beats always count AXIS_KEEP_WIDTH bytes.
- Memory write port: registered, one cycle after acceptance. wr_ptr increments mod 2^ADDR_WIDTH, so frames may wrap; the consumer wraps its read address identically.
- Descriptor latency: the FIFO push coincides with the last memory write, one cycle after the tlast beat is accepted. m_desc_valid rises the cycle after the push (first-word-fall-through output).
- Descriptor handshake: a descriptor is popped on m_desc_valid & m_desc_ready. Outputs are stable while valid & !ready.
- free_cnt update: new = free_cnt − committed_beats + (s_rel_valid ? s_rel_beats : 0), applied in the same cycle for simultaneous commit and release. A release that would exceed 2^ADDR_WIDTH saturates at 2^ADDR_WIDTH.
- Reset mid-frame: the partial frame is lost; no descriptor is emitted; drop_cnt is cleared.

Decomposition:
- Package pkt_rx_pkg:
  - rx_state_t enum {S_IDLE, S_RECV, S_DROP}
  - rx_desc_t struct {addr, pkt_len, byte_len}
  - constants for ring size and bytes-per-beat
- Sub-module desc_fifo: synchronous FIFO of rx_desc_t, depth DESC_DEPTH, first-word-fall-through, full/empty flags, async active-low reset.

Test Plan:
- Reset, 3-beat frame (last tkeep = 0x0000_0000_0000_00FF) → writes at addr 0,1,2 on consecutive cycles; descriptor {addr 0, pkt_len 3, byte_len 136}; free_cnt 253.
- Two back-to-back 1-beat frames (full tkeep), m_desc_ready = 0 → two descriptors queued {0,1,64},{1,1,64}; popped in order when ready goes high.
- Fill the ring with 255 beats committed, no release, then a 2-beat frame → first beat written at 255, second beat dropped, wr_ptr back to 255, drop_cnt = 1, no descriptor.
- Descriptor FIFO full (4 pending, ready = 0), fifth 1-beat frame → drop_cnt increments, free_cnt unchanged, no fifth descriptor.
- wr_ptr = 254, 4-beat frame → writes at 254, 255, 0, 1; descriptor addr 254, pkt_len 4.
- Commit of 4 beats in the same cycle as release of 10 → free_cnt net +6. Separately, assert reset mid-frame → outputs 0, no descriptor, tready high one cycle after deassertion.
